// File: rtl/tq_zigzag_scan_4x4_pkg.sv
// rtl/tq_zigzag_scan_4x4_pkg.sv - shared dct_quant constants and types for the 4x4 zig-zag scan stage
package tq_zigzag_scan_4x4_pkg;

    localparam int COEFF_W = 15;

    // Raster index of each zig-zag scan position (H.264 frame scan)
    localparam logic [3:0] ZZ4X4 [16] = '{
        4'd0,  4'd1,  4'd4,  4'd8,
        4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10,
        4'd7,  4'd11, 4'd14, 4'd15
    };

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

endpackage

// File: rtl/tq_cavlc_summary_4x4.sv
// rtl/tq_cavlc_summary_4x4.sv - combinational CAVLC TotalCoeff/TrailingOnes/TotalZeros of a zig-zag ordered 4x4 block
module tq_cavlc_summary_4x4 #(
    parameter int COEFF_W = 15
) (
    input  logic [16*COEFF_W-1:0] zz_coeff,
    output logic [4:0]            total_coeff,
    output logic [1:0]            trailing_ones,
    output logic [3:0]            total_zeros
);

    logic [COEFF_W-1:0] lv;
    logic [3:0]         hi_pos;
    logic               t1_done;

    // Count nonzeros, locate the highest nonzero, then walk down for trailing +-1 levels
    always_comb begin
        lv            = '0;
        hi_pos        = 4'd0;
        total_coeff   = 5'd0;
        trailing_ones = 2'd0;
        t1_done       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lv = zz_coeff[i*COEFF_W +: COEFF_W];
            if (lv != '0) begin
                total_coeff = total_coeff + 5'd1;
                hi_pos      = 4'(i);
            end
        end
        for (int i = 15; i >= 0; i--) begin
            lv = zz_coeff[i*COEFF_W +: COEFF_W];
            if (lv != '0 && !t1_done) begin
                // most-negative value is neither +1 nor -1, so it ends the run
                if ((lv == {{(COEFF_W-1){1'b0}}, 1'b1} || lv == '1) && trailing_ones != 2'd3) begin
                    trailing_ones = trailing_ones + 2'd1;
                end else begin
                    t1_done = 1'b1;
                end
            end
        end
        // zeros below the highest nonzero = (hi_pos + 1) - total_coeff
        total_zeros = (total_coeff == 5'd0) ? 4'd0 : hi_pos - 4'(total_coeff - 5'd1);
    end

endmodule

// File: rtl/tq_zigzag_scan_4x4.sv
// rtl/tq_zigzag_scan_4x4.sv - 4x4 block capture, zig-zag serialiser and CAVLC summary; TQ_ZZ_SKIP_ZERO_EN skips zero levels
module tq_zigzag_scan_4x4 #(
    parameter int COEFF_W  = tq_zigzag_scan_4x4_pkg::COEFF_W,
    parameter int SCAN_REV = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [16*COEFF_W-1:0]  blk_coeff_i,
    output logic                   coeff_valid_o,
    input  logic                   coeff_ready_i,
    output logic [COEFF_W-1:0]     coeff_o,
    output logic [3:0]             coeff_idx_o,
    output logic [3:0]             coeff_run_o,
    output logic                   coeff_last_o,
    output logic [4:0]             total_coeff_o,
    output logic [1:0]             trailing_ones_o,
    output logic [3:0]             total_zeros_o
);

    import tq_zigzag_scan_4x4_pkg::*;

    localparam logic [3:0] CNT_START = (SCAN_REV != 0) ? 4'd15 : 4'd0;
    localparam logic [3:0] CNT_END   = (SCAN_REV != 0) ? 4'd0  : 4'd15;

    state_e                 state_q;
    logic                   rdy_q;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_next;
    logic [COEFF_W-1:0]     lv_q [16];
    logic [4:0]             tc_q;
    logic [1:0]             t1_q;
    logic [3:0]             tz_q;
    logic [16*COEFF_W-1:0]  zz_vec;
    logic [4:0]             sum_tc;
    logic [1:0]             sum_t1;
    logic [3:0]             sum_tz;
    logic [3:0]             last_pos;
    logic                   beat_ok;
    logic                   beat_fire;

    // Reorder the raster-packed input block into zig-zag order
    always_comb begin
        zz_vec = '0;
        for (int i = 0; i < 16; i++) begin
            zz_vec[i*COEFF_W +: COEFF_W] = blk_coeff_i[int'(ZZ4X4[i])*COEFF_W +: COEFF_W];
        end
    end

    tq_cavlc_summary_4x4 #(
        .COEFF_W (COEFF_W)
    ) u_summary (
        .zz_coeff      (zz_vec),
        .total_coeff   (sum_tc),
        .trailing_ones (sum_t1),
        .total_zeros   (sum_tz)
    );

    assign cnt_next = (SCAN_REV != 0) ? cnt_q - 4'd1 : cnt_q + 4'd1;

`ifdef TQ_ZZ_SKIP_ZERO_EN
    logic [3:0] last_pos_c;
    logic [3:0] last_pos_q;
    logic [3:0] run_q;
    logic [3:0] hi_c;
    logic [3:0] lo_c;

    // Final emitted position: last nonzero in scan order, or the final scan slot for an all-zero block
    always_comb begin
        hi_c = 4'd15;
        lo_c = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (zz_vec[i*COEFF_W +: COEFF_W] != '0) hi_c = 4'(i);
        end
        for (int i = 15; i >= 0; i--) begin
            if (zz_vec[i*COEFF_W +: COEFF_W] != '0) lo_c = 4'(i);
        end
        last_pos_c = (SCAN_REV != 0) ? lo_c : hi_c;
    end

    assign last_pos    = last_pos_q;
    assign beat_ok     = (lv_q[cnt_q] != '0) || (cnt_q == last_pos_q);
    assign coeff_run_o = (state_q == SCAN && tc_q != 5'd0) ? run_q : 4'd0;
`else
    assign last_pos    = CNT_END;
    assign beat_ok     = 1'b1;
    assign coeff_run_o = 4'd0;
`endif

    assign blk_ready_o     = rdy_q;
    assign coeff_valid_o   = (state_q == SCAN) && beat_ok;
    assign coeff_o         = (state_q == SCAN) ? lv_q[cnt_q] : '0;
    assign coeff_idx_o     = (state_q == SCAN) ? cnt_q : 4'd0;
    assign coeff_last_o    = coeff_valid_o && (cnt_q == last_pos);
    assign total_coeff_o   = tc_q;
    assign trailing_ones_o = t1_q;
    assign total_zeros_o   = tz_q;
    assign beat_fire       = coeff_valid_o && coeff_ready_i;

    // Block accept, scan counter walk and return to IDLE after the last beat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= 4'd0;
            tc_q    <= 5'd0;
            t1_q    <= 2'd0;
            tz_q    <= 4'd0;
            for (int i = 0; i < 16; i++) lv_q[i] <= '0;
`ifdef TQ_ZZ_SKIP_ZERO_EN
            last_pos_q <= 4'd0;
            run_q      <= 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (blk_valid_i && rdy_q) begin
                        for (int i = 0; i < 16; i++) lv_q[i] <= zz_vec[i*COEFF_W +: COEFF_W];
                        tc_q    <= sum_tc;
                        t1_q    <= sum_t1;
                        tz_q    <= sum_tz;
                        cnt_q   <= CNT_START;
                        rdy_q   <= 1'b0;
                        state_q <= SCAN;
`ifdef TQ_ZZ_SKIP_ZERO_EN
                        last_pos_q <= last_pos_c;
                        run_q      <= 4'd0;
`endif
                    end
                end
                SCAN: begin
                    if (beat_fire) begin
                        if (coeff_last_o) begin
                            state_q <= IDLE;
                            rdy_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_next;
                        end
`ifdef TQ_ZZ_SKIP_ZERO_EN
                        run_q <= 4'd0;
                    end else if (!beat_ok) begin
                        cnt_q <= cnt_next;
                        run_q <= run_q + 4'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tq_zigzag_scan_4x4.md
Name: tq_zigzag_scan_4x4

Overview:
- Stage directly downstream of the 4x4 forward quantiser in the H.264 dct_quant path.
- Captures one quantised 4x4 block, 16 signed 15-bit levels, in a single valid/ready transfer.
- Serialises the levels one per beat in H.264 frame zig-zag order, with valid/ready output handshake.
- Produces the CAVLC block summary (TotalCoeff, TrailingOnes, TotalZeros) for the entropy coder.

Parameters:
- COEFF_W, 15: width of one signed level, in and out.
- SCAN_REV, 0: 0 = emit zig-zag index 0→15; 1 = emit 15→0 (CAVLC order).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- blk_valid_i  in  1  block available
- blk_ready_o  out  1  block accepted when blk_valid_i && blk_ready_o at clk_i rise
- blk_coeff_i  in  16*COEFF_W  raster-packed; level (row r, col c) at [(4r+c)*COEFF_W +: COEFF_W]
- coeff_valid_o  out  1  serial beat valid
- coeff_ready_i  in  1  downstream accepts beat
- coeff_o  out  COEFF_W  signed level
- coeff_idx_o  out  4  zig-zag position of coeff_o
- coeff_run_o  out  4  zeros skipped before this beat (skip mode only, else 0)
- coeff_last_o  out  1  final beat of block
- total_coeff_o  out  5  nonzero count, 0..16
- trailing_ones_o  out  2  TrailingOnes, 0..3
- total_zeros_o  out  4  TotalZeros, 0..15

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous, active-low.
- Reset values: state IDLE; every output 0, including blk_ready_o. blk_ready_o rises on the first clk_i edge after reset release.
- Zig-zag table, scan index → raster index: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- FSM IDLE:
  - blk_ready_o=1, coeff_valid_o=0.
  - On handshake: register the 16 levels, register the summary, load the scan counter (0, or 15 if SCAN_REV), drop blk_ready_o, go to SCAN.
- FSM SCAN:
  - coeff_valid_o=1 with coeff_o/coeff_idx_o for the current counter.
  - On coeff_valid_o && coeff_ready_i, advance the counter (+1, or −1 if SCAN_REV).
  - On the beat with coeff_last_o, return to IDLE; blk_ready_o=1 on the next cycle.
- Throughput: no overlap. Block accept → first beat is 1 cycle. Minimum period is 17 cycles/block without skip.
- Stall: while coeff_valid_o && !coeff_ready_i, all coeff_* and summary outputs hold stable.
- Summary outputs: stable from the first beat to the last beat of the block. Remaining boundary values:
  - total_coeff_o = count of nonzero levels.
  - total_zeros_o = zeros at zig-zag positions below the highest nonzero position; 0 when total_coeff_o=0.
  - trailing_ones_o = count of consecutive ±1 levels scanning nonzeros from the highest position down, saturating at 3, stopping at the first |level|>1.
- Arithmetic: levels pass through unmodified. The most-negative value −2^(COEFF_W−1) is treated as nonzero and |x|>1.
- Reset mid-SCAN: immediate return to IDLE, outputs cleared, the block is discarded.
- blk_valid_i during SCAN is ignored; blk_ready_o=0.

Optional Feature:
- Macro: TQ_ZZ_SKIP_ZERO_EN.
- Defined:
  - Zero levels are not emitted. Each skipped position costs one cycle with coeff_valid_o=0.
  - coeff_run_o = zeros skipped since the previous emitted beat or the scan start.
  - coeff_last_o is set on the last nonzero in emission order; remaining positions are not visited.
  - All-zero block: exactly one beat with coeff_o=0, coeff_idx_o=final scan position, coeff_run_o=0, coeff_last_o=1, total_coeff_o=0.
- Undefined: all 16 positions are emitted, coeff_run_o tied 0, coeff_last_o on the 16th beat.

Decomposition:
- Add to the shared dct_quant package:
  - ZZ4X4 constant array (raster index per scan index).
  - COEFF_W localparam.
  - State enum {IDLE, SCAN}.
- One sub-module: tq_cavlc_summary_4x4, purely combinational. Input is the 16 zig-zag-ordered levels; outputs are total_coeff, trailing_ones, total_zeros. Its outputs are registered at block accept.

Test Plan:
- Raster block with level = raster index + 1, coeff_ready_i=1, SCAN_REV=0 → coeff_o 1,2,5,9,6,3,4,7,10,13,14,11,8,12,15,16 on consecutive cycles. last on 16th beat. total_coeff=16, trailing_ones=0, total_zeros=0.
- Zig-zag positions 0..3 = {3,−1,1,−1}, rest 0 → total_coeff=4, trailing_ones=3, total_zeros=0. With SCAN_REV=1 the first beat has idx 15.
- Zig-zag positions 2 = −2 and 9 = 1, rest 0 → total_coeff=2, trailing_ones=1, total_zeros=8.
- Drive coeff_ready_i=0 for 5 cycles at beat 7 → coeff_o/idx held 5 cycles. Beat order unchanged; no beat dropped or duplicated.
- Assert rst_n_i low mid-SCAN (beat 4) asynchronously between edges → outputs 0 immediately. After release, blk_ready_o=1 after one edge; the next block scans from idx 0.
- TQ_ZZ_SKIP_ZERO_EN with zig-zag positions 0 = 5 and 6 = −1 → beats (5, idx0, run0) then (−1, idx6, run5, last). All-zero block → single beat, last=1, total_coeff=0.
